// File: rtl/cint_call_sequencer.sv
// cint_call_sequencer: XPT micro-step counter, interrupt request latching/arbitration
// and CINT0_CALL entry. Optional macro CINT_IRQ_EDGE_EN selects rising-edge request latching.
module cint_call_sequencer #(
  parameter int unsigned NIRQ       = 4,
  parameter int unsigned START_STEP = 6,
  parameter int unsigned LAST_STEP  = 18,
  localparam int unsigned VW        = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_din,
  input  logic            step_ready,
  input  logic            reset_xpt,
  input  logic            reti,
  output logic [4:0]      XPT,
  output logic [4:0]      notXPT,
  output logic            notCINT0_CALL,
  output logic [VW-1:0]   cint_vec,
  output logic            CM1,
  output logic [NIRQ-1:0] pending,
  output logic            overrun
);

  localparam logic [4:0] W_START = 5'(START_STEP);
  localparam logic [4:0] W_LAST  = 5'(LAST_STEP);

  typedef enum logic {ST_RUN, ST_CALL} state_t;

  state_t          r_state, w_state_nx;
  logic [4:0]      r_xpt, w_xpt_nx;
  logic [4:0]      r_nxpt;
  logic            r_ncall, w_ncall_nx;
  logic [VW-1:0]   r_vec, w_vec_nx;
  logic            r_cm1, w_cm1_nx;
  logic [NIRQ-1:0] r_pend, w_pend_nx;
  logic [NIRQ-1:0] r_mask;
  logic            r_ovr, w_ovr_nx;
  logic [NIRQ-1:0] w_set, w_clr, w_cand;
  logic [VW-1:0]   w_idx;
  logic            w_any, w_exit;

`ifdef CINT_IRQ_EDGE_EN
  logic [NIRQ-1:0] r_irq_d;

  always_ff @(posedge clk) begin
    if (rst) r_irq_d <= '0;
    else     r_irq_d <= irq;
  end

  assign w_set = irq & ~r_irq_d;
`else
  assign w_set = irq;
`endif

  assign w_cand = r_pend & ~r_mask;

  // Fixed priority: lowest set index wins.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (w_cand[i] && !w_any) begin
        w_idx = VW'(i);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_xpt_nx   = r_xpt;
    w_ncall_nx = r_ncall;
    w_vec_nx   = r_vec;
    w_cm1_nx   = r_cm1;
    w_ovr_nx   = r_ovr;
    w_clr      = '0;
    w_exit     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (reset_xpt) begin
          if (w_any && !r_cm1) begin
            w_state_nx = ST_CALL;
            w_xpt_nx   = W_START;
            w_vec_nx   = w_idx;
            w_ncall_nx = 1'b0;
          end else begin
            w_xpt_nx = '0;
          end
        end else if (step_ready) begin
          w_xpt_nx = r_xpt + 5'd1;
        end
      end
      ST_CALL: begin
        if (reset_xpt) begin
          w_exit     = 1'b1;
          w_state_nx = ST_RUN;
          w_xpt_nx   = '0;
          w_ncall_nx = 1'b1;
          w_clr      = NIRQ'(1) << r_vec;
          w_cm1_nx   = 1'b1;
        end else if (step_ready) begin
          // Watchdog: stepping beyond the last legal step aborts the call.
          if (r_xpt >= W_LAST) begin
            w_ovr_nx   = 1'b1;
            w_xpt_nx   = '0;
            w_ncall_nx = 1'b1;
            w_state_nx = ST_RUN;
          end else begin
            w_xpt_nx = r_xpt + 5'd1;
          end
        end
      end
      default: w_state_nx = ST_RUN;
    endcase
    if (reti && !w_exit) w_cm1_nx = 1'b0;
    w_pend_nx = (r_pend | w_set) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_xpt   <= '0;
      r_nxpt  <= '1;
      r_ncall <= 1'b1;
      r_vec   <= '0;
      r_cm1   <= 1'b0;
      r_pend  <= '0;
      r_mask  <= '1;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_xpt   <= w_xpt_nx;
      r_nxpt  <= ~w_xpt_nx;
      r_ncall <= w_ncall_nx;
      r_vec   <= w_vec_nx;
      r_cm1   <= w_cm1_nx;
      r_pend  <= w_pend_nx;
      if (mask_we) r_mask <= mask_din;
      r_ovr   <= w_ovr_nx;
    end
  end

  assign XPT           = r_xpt;
  assign notXPT        = r_nxpt;
  assign notCINT0_CALL = r_ncall;
  assign cint_vec      = r_vec;
  assign CM1           = r_cm1;
  assign pending       = r_pend;
  assign overrun       = r_ovr;

endmodule

// File: doc/cint_call_sequencer.md
Name: cint_call_sequencer

Overview:
- Owns the 5-bit micro-step counter XPT and the interrupt-call entry for the NOR-style core.
- Latches interrupt requests and arbitrates them by fixed priority at instruction boundaries.
- Forces the CINT0_CALL micro-sequence: asserts notCINT0_CALL low and steps XPT from START_STEP until the step decoder returns the reset-XPT strobe.
- Tracks the CM1 "in interrupt" mode flag, which blocks re-entry until return-from-interrupt.

Parameters:
- NIRQ, 4: number of interrupt request lines; index 0 has the highest priority.
- START_STEP, 6: XPT value loaded on interrupt-call entry.
- LAST_STEP, 18: final legal step of the call sequence; used by the overrun watchdog.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- irq  in  NIRQ  level interrupt requests.
- mask_we  in  1  write strobe for the mask register.
- mask_din  in  NIRQ  new mask value; 1 means masked.
- step_ready  in  1  XPT may advance this cycle (memory/bus not stalled).
- reset_xpt  in  1  end-of-instruction strobe from the step decoders (PR_Reset_XPT).
- reti  in  1  return-from-interrupt strobe; clears CM1.
- XPT  out  5  current micro-step.
- notXPT  out  5  bitwise complement of XPT, registered alongside it.
- notCINT0_CALL  out  1  low while the call sequence is active.
- cint_vec  out  clog2(NIRQ)  index of the interrupt being serviced.
- CM1  out  1  interrupt mode flag.
- pending  out  NIRQ  latched, not-yet-serviced requests.
- overrun  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: state=RUN, XPT=0, notXPT=5'b11111, notCINT0_CALL=1, cint_vec=0, CM1=0, pending=0, mask=all ones, overrun=0. Reset overrides everything, including mid-call.
- Request latching, every cycle: pending <= (pending | irq) & ~clear, where clear is the serviced bit at call exit. A set and clear of the same bit in the same cycle resolves to clear; a still-high level re-latches on the next cycle.
- mask_we loads the mask in one cycle; the new value is used from the next cycle.
- RUN state:
  - reset_xpt=1 with no call taken: XPT <= 0.
  - Otherwise, step_ready=1: XPT <= XPT+1.
  - Otherwise XPT holds.
  - Arbitration happens only in the cycle reset_xpt=1. Candidates are pending & ~mask. If any candidate exists and CM1=0: take the lowest set index.
  - On a take: next state CALL, XPT <= START_STEP, cint_vec <= that index, notCINT0_CALL <= 0. This takes priority over XPT <= 0.
- CALL state:
  - XPT increments by 1 on each step_ready cycle.
  - reset_xpt=1 exits the call. XPT <= 0, notCINT0_CALL <= 1, pending[cint_vec] cleared, CM1 <= 1, next state RUN. No arbitration happens in this exit cycle, because CM1 is effectively set.
- Watchdog: in CALL, if XPT would advance past LAST_STEP without reset_xpt, then overrun <= 1, XPT <= 0, notCINT0_CALL <= 1, state RUN. CM1 is unchanged and the pending bit stays set. overrun clears only on rst.
- reti=1 clears CM1 next cycle. If reti and call exit coincide, CM1 ends up 1: the exit wins.
- Wrap-around: in RUN, XPT 31 + step_ready wraps to 0. No flag is raised.
- notXPT always equals ~XPT on the same cycle; both are registered.
- Latency: request to call entry is 1 cycle after the latch cycle, plus the wait for the next reset_xpt.

Optional Feature:
- Macro CINT_IRQ_EDGE_EN.
- Defined: requests latch on the rising edge only, using an irq_d register (reset 0). pending |= irq & ~irq_d. A held-high line produces exactly one service.
- Undefined: level latching as specified above.

Test Plan:
- Reset, then irq=4'b0100, mask_din=0 with mask_we. Pulse reset_xpt → next cycle XPT=6, notCINT0_CALL=0, cint_vec=2, notXPT=5'b11001.
- In CALL, step_ready held high, reset_xpt pulsed when XPT=18 → XPT=0, CM1=1, pending[2]=0 with irq dropped. A second reset_xpt with irq[1] pending takes no call until reti.
- irq=4'b1010 unmasked, then reset_xpt → cint_vec=1. After exit plus reti plus the next reset_xpt → cint_vec=3.
- mask=4'b0001, irq=4'b0001, reset_xpt → no call: XPT=0 and notCINT0_CALL stays 1.
- CALL with reset_xpt never asserted → overrun=1 on the cycle XPT would reach 19, XPT=0, state RUN.
- rst asserted at XPT=12 mid-call → all outputs return to reset values on the next cycle. With CINT_IRQ_EDGE_EN, irq[0] held high produces exactly one call.
